// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX frame scheduler.
// Holds the FSM encoding, control-register width and parameter limits.
package uart_pkg;

  localparam int CTRL_W        = 8;
  localparam int NUM_REQ_MIN   = 1;
  localparam int NUM_REQ_MAX   = 8;
  localparam int MAX_FRAME_MIN = 1;
  localparam int MAX_FRAME_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2,
    CFG  = 2'd3
  } sched_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && (j == cand) && req[j]) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Frame-level scheduler sharing the UART TX FIFO write port among requesters
// and sequencing control-register loads so they land only between frames.
//
// state | meaning
// IDLE  | no owner; cfg load has priority, else round-robin grant
// XFER  | frame owner streams bytes, at most one write every 2 clks
// GAP   | one dead cycle after a frame, forces re-arbitration
// CFG   | CtrlReg*_o latched on entry; p_We_o/cfg_ack_o pulse on exit
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_FRAME = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 frame_err_o,
  input  logic                 cfg_req_i,
  input  logic [CTRL_W-1:0]    cfg_reg1_i,
  input  logic [CTRL_W-1:0]    cfg_reg2_i,
  input  logic [CTRL_W-1:0]    cfg_reg3_i,
  output logic                 cfg_ack_o,
  output logic [7:0]           tx_data_o,
  output logic                 n_tx_we_o,
  input  logic                 p_tx_full_i,
  output logic                 p_We_o,
  output logic [CTRL_W-1:0]    CtrlReg1_o,
  output logic [CTRL_W-1:0]    CtrlReg2_o,
  output logic [CTRL_W-1:0]    CtrlReg3_o,
  output logic                 busy_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  sched_state_t         state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gidx;
  logic [7:0]           cnt;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 n_we_q;
  logic [7:0]           tx_data_q;
  logic                 p_we_q;
  logic                 cfg_ack_q;
  logic                 frame_err_q;
  logic [CTRL_W-1:0]    ctrl1_q;
  logic [CTRL_W-1:0]    ctrl2_q;
  logic [CTRL_W-1:0]    ctrl3_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  logic                 cur_valid;
  logic                 cur_last;
  logic [7:0]           cur_byte;
  logic                 write_ok;
  logic                 cnt_at_limit;
  logic [7:0]           cnt_inc;
  logic [IDX_W-1:0]     ptr_next;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_byte  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx == IDX_W'(k)) begin
        cur_valid = req_valid_i[k];
        cur_last  = req_last_i[k];
        cur_byte  = req_data_i[8*k +: 8];
      end
    end
  end

  // n_we_q low means a byte went out last cycle; skipping the next cycle
  // gives the core's full flag time to reflect that write.
  assign write_ok     = (state == XFER) && (grant_q != '0) && cur_valid &&
                        !p_tx_full_i && n_we_q;
  assign cnt_at_limit = (cnt >= 8'(MAX_FRAME - 1));
  assign cnt_inc      = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign ptr_next     = IDX_W'(wrap_inc(int'(gidx), NUM_REQ));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gidx        <= '0;
      cnt         <= '0;
      grant_q     <= '0;
      ready_q     <= '0;
      n_we_q      <= 1'b1;
      tx_data_q   <= '0;
      p_we_q      <= 1'b0;
      cfg_ack_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ctrl1_q     <= '0;
      ctrl2_q     <= '0;
      ctrl3_q     <= '0;
    end else begin
      n_we_q      <= 1'b1;
      ready_q     <= '0;
      p_we_q      <= 1'b0;
      cfg_ack_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_req_i) begin
            state   <= CFG;
            ctrl1_q <= cfg_reg1_i;
            ctrl2_q <= cfg_reg2_i;
            ctrl3_q <= cfg_reg3_i;
          end else if (arb_any) begin
            state   <= XFER;
            grant_q <= arb_gnt;
            gidx    <= arb_idx;
            cnt     <= '0;
          end
        end
        XFER: begin
          if (write_ok) begin
            n_we_q    <= 1'b0;
            tx_data_q <= cur_byte;
            ready_q   <= grant_q;
            cnt       <= cnt_inc;
            if (cur_last || cnt_at_limit) begin
              state       <= GAP;
              grant_q     <= '0;
              rr_ptr      <= ptr_next;
              frame_err_q <= !cur_last;
            end
          end
        end
        GAP: begin
          state <= IDLE;
          cnt   <= '0;
        end
        CFG: begin
          p_we_q    <= 1'b1;
          cfg_ack_q <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign grant_o     = grant_q;
  assign frame_err_o = frame_err_q;
  assign cfg_ack_o   = cfg_ack_q;
  assign tx_data_o   = tx_data_q;
  assign n_tx_we_o   = n_we_q;
  assign p_We_o      = p_we_q;
  assign CtrlReg1_o  = ctrl1_q;
  assign CtrlReg2_o  = ctrl2_q;
  assign CtrlReg3_o  = ctrl3_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: drivers push expected bytes and
// config loads into queues, a negedge monitor pops and compares.
module tb_uart_tx_scheduler;
  localparam int NR = 2;
  localparam int MF = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready_o;
  logic [NR-1:0]   grant_o;
  logic            frame_err_o;
  logic            cfg_req;
  logic [7:0]      cfg_reg1, cfg_reg2, cfg_reg3;
  logic            cfg_ack_o;
  logic [7:0]      tx_data_o;
  logic            n_tx_we_o;
  logic            p_tx_full;
  logic            p_We_o;
  logic [7:0]      CtrlReg1_o, CtrlReg2_o, CtrlReg3_o;
  logic            busy_o;

  logic            v [NR];
  logic            l [NR];
  logic [7:0]      d [NR];

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int k = 0; k < NR; k++) begin
      req_valid[k]        = v[k];
      req_last[k]         = l[k];
      req_data[8*k +: 8]  = d[k];
    end
  end

  uart_tx_scheduler #(.NUM_REQ(NR), .MAX_FRAME(MF)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .frame_err_o (frame_err_o),
    .cfg_req_i   (cfg_req),
    .cfg_reg1_i  (cfg_reg1),
    .cfg_reg2_i  (cfg_reg2),
    .cfg_reg3_i  (cfg_reg3),
    .cfg_ack_o   (cfg_ack_o),
    .tx_data_o   (tx_data_o),
    .n_tx_we_o   (n_tx_we_o),
    .p_tx_full_i (p_tx_full),
    .p_We_o      (p_We_o),
    .CtrlReg1_o  (CtrlReg1_o),
    .CtrlReg2_o  (CtrlReg2_o),
    .CtrlReg3_o  (CtrlReg3_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed { logic [7:0] r1; logic [7:0] r2; logic [7:0] r3; } cfg_t;

  logic [7:0]    exp_q0 [$];
  logic [7:0]    exp_q1 [$];
  cfg_t          exp_cfg [$];
  int            strobe_cyc [$];
  logic [NR-1:0] grant_log [$];
  logic [NR-1:0] owner = '0;
  logic [NR-1:0] prev_grant = '0;
  int            last_strobe = -100;
  int            frame_bytes = 0;
  int            err_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (grant_o != '0 && prev_grant == '0) begin
        grant_log.push_back(grant_o);
        frame_bytes = 0;
      end
      if (grant_o != '0) owner = grant_o;
      prev_grant = grant_o;
      if (!n_tx_we_o) begin
        strobe_cyc.push_back(cyc);
        chk("strobe_spacing", 32'(cyc - last_strobe >= 2), 1);
        last_strobe = cyc;
        chk("ready_owner", 32'(req_ready_o), 32'(owner));
        chk("ready_onehot", 32'($onehot(req_ready_o)), 1);
        frame_bytes++;
        if (req_ready_o[0]) begin
          chk("byte_expected_r0", 32'(exp_q0.size() != 0), 1);
          if (exp_q0.size() != 0) chk("data_r0", 32'(tx_data_o), 32'(exp_q0.pop_front()));
        end else if (req_ready_o[1]) begin
          chk("byte_expected_r1", 32'(exp_q1.size() != 0), 1);
          if (exp_q1.size() != 0) chk("data_r1", 32'(tx_data_o), 32'(exp_q1.pop_front()));
        end
      end else begin
        chk("ready_without_we", 32'(req_ready_o), 0);
      end
      chk("ack_with_pwe", 32'(cfg_ack_o), 32'(p_We_o));
      if (p_We_o) begin
        chk("cfg_expected", 32'(exp_cfg.size() != 0), 1);
        if (exp_cfg.size() != 0) begin
          cfg_t e;
          e = exp_cfg.pop_front();
          chk("ctrl1", 32'(CtrlReg1_o), 32'(e.r1));
          chk("ctrl2", 32'(CtrlReg2_o), 32'(e.r2));
          chk("ctrl3", 32'(CtrlReg3_o), 32'(e.r3));
        end
      end
      if (frame_err_o) begin
        err_count++;
        chk("err_with_strobe", 32'(n_tx_we_o), 0);
        chk("err_frame_len", 32'(frame_bytes), MF);
      end
    end
  end

  task automatic send(input int k, input logic [7:0] base, input logic [7:0] step,
                      input int n, input bit end_last);
    logic [7:0] b;
    int t;
    for (int i = 0; i < n; i++) begin
      b    = base + 8'(i) * step;
      v[k] = 1'b1;
      d[k] = b;
      l[k] = end_last && (i == n - 1);
      if (k == 0) exp_q0.push_back(b);
      else        exp_q1.push_back(b);
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (req_ready_o[k]) break;
      end
      chk($sformatf("accept_r%0d_b%0d", k, i), 32'(req_ready_o[k]), 1);
      if (!req_ready_o[k]) break;
    end
    v[k] = 1'b0;
    l[k] = 1'b0;
  endtask

  task automatic wait_grant(input logic [NR-1:0] g, input string nm);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (grant_o == g) break;
    end
    chk(nm, 32'(grant_o), 32'(g));
  endtask

  logic [NR-1:0] exp_g3 [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [NR-1:0] exp_g6 [3] = '{2'b10, 2'b01, 2'b10};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_s;
    for (int k = 0; k < NR; k++) begin v[k] = 1'b0; l[k] = 1'b0; d[k] = '0; end
    cfg_req = 1'b0; cfg_reg1 = '0; cfg_reg2 = '0; cfg_reg3 = '0; p_tx_full = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_n_we", 32'(n_tx_we_o), 1);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_pwe", 32'(p_We_o), 0);
    chk("rst_data", 32'(tx_data_o), 0);
    chk("rst_ctrl", {8'h0, CtrlReg1_o, CtrlReg2_o, CtrlReg3_o}, 0);
    chk("rst_ack_err", {cfg_ack_o, frame_err_o}, 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst = 1'b1;
    @(negedge clk);

    // single 3-byte frame from req0
    strobe_cyc.delete();
    send(0, 8'h11, 8'h11, 3, 1'b1);
    chk("t2_gap_grant", 32'(grant_o), 0);
    chk("t2_gap_busy", 32'(busy_o), 1);
    @(negedge clk);
    chk("t2_idle_busy", 32'(busy_o), 0);
    chk("t2_strobes", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      chk("t2_gap01", strobe_cyc[1] - strobe_cyc[0], 2);
      chk("t2_gap12", strobe_cyc[2] - strobe_cyc[1], 2);
    end
    chk("t2_drained", exp_q0.size(), 0);

    // fairness: pointer is 1 after req0's frame, so req1 wins first
    grant_log.delete();
    fork
      begin send(0, 8'hA0, 8'h01, 2, 1'b1); send(0, 8'hA2, 8'h01, 2, 1'b1); end
      begin send(1, 8'hB0, 8'h01, 2, 1'b1); send(1, 8'hB2, 8'h01, 2, 1'b1); end
    join
    repeat (3) @(negedge clk);
    chk("t3_frames", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk($sformatf("t3_grant%0d", i), 32'(grant_log[i]), 32'(exp_g3[i]));

    // back-pressure for 10 clks after the 2nd byte
    fork
      send(0, 8'h41, 8'h01, 4, 1'b1);
      begin
        cnt_s = 0;
        for (int t = 0; t < 200 && cnt_s < 2; t++) begin
          @(negedge clk);
          if (!n_tx_we_o) cnt_s++;
        end
        chk("t4_two_bytes", cnt_s, 2);
        p_tx_full = 1'b1;
        cnt_s = 0;
        repeat (10) begin
          @(negedge clk);
          if (!n_tx_we_o) cnt_s++;
        end
        chk("t4_no_strobe_full", cnt_s, 0);
        p_tx_full = 1'b0;
        @(negedge clk);
        chk("t4_resume", 32'(n_tx_we_o), 0);
      end
    join
    repeat (3) @(negedge clk);

    // config request raised during a 4-byte frame
    fork
      send(0, 8'h51, 8'h01, 4, 1'b1);
      begin
        wait_grant(2'b01, "t5_grant");
        cfg_req = 1'b1; cfg_reg1 = 8'hC5; cfg_reg2 = 8'h34; cfg_reg3 = 8'h12;
        exp_cfg.push_back('{r1: 8'hC5, r2: 8'h34, r3: 8'h12});
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (cfg_ack_o) break;
        end
        chk("t5_ack", 32'(cfg_ack_o), 1);
        chk("t5_after_frame", exp_q0.size(), 0);
        cfg_req = 1'b0;
        @(negedge clk);
        chk("t5_ack_width", 32'(cfg_ack_o), 0);
        chk("t5_ctrl", {8'h0, CtrlReg1_o, CtrlReg2_o, CtrlReg3_o}, 32'h00C53412);
      end
    join
    repeat (5) @(negedge clk);
    chk("t5_cfg_drained", exp_cfg.size(), 0);

    // forced release: req1 has 6 bytes without last, then a closing byte
    grant_log.delete();
    err_count = 0;
    fork
      send(1, 8'h61, 8'h01, 7, 1'b1);
      begin
        wait_grant(2'b10, "t6_grant_r1");
        send(0, 8'h71, 8'h01, 1, 1'b1);
      end
    join
    repeat (3) @(negedge clk);
    chk("t6_err_count", err_count, 1);
    chk("t6_frames", grant_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < grant_log.size()) chk($sformatf("t6_grant%0d", i), 32'(grant_log[i]), 32'(exp_g6[i]));

    // reset in the middle of a frame
    v[0] = 1'b1; d[0] = 8'h77; l[0] = 1'b0;
    exp_q0.push_back(8'h77);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!n_tx_we_o) break;
    end
    chk("t1_first_byte", 32'(n_tx_we_o), 0);
    v[0] = 1'b0;
    @(negedge clk);
    chk("t1_mid_frame", {busy_o, grant_o}, 32'b101);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t1_rst_n_we", 32'(n_tx_we_o), 1);
      chk("t1_rst_grant", 32'(grant_o), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t1_after_n_we", 32'(n_tx_we_o), 1);
    chk("t1_after_grant", 32'(grant_o), 0);
    chk("t1_after_pwe", 32'(p_We_o), 0);
    chk("t1_after_ctrl", {8'h0, CtrlReg1_o, CtrlReg2_o, CtrlReg3_o}, 0);
    chk("t1_after_busy", 32'(busy_o), 0);

    chk("end_q0_empty", exp_q0.size(), 0);
    chk("end_q1_empty", exp_q1.size(), 0);
    chk("end_cfg_empty", exp_cfg.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
